// File: rtl/interval_meter.sv
// Measures start-to-stop duration as whole time-base ticks plus residual clock cycles,
// aborting with a timeout pulse when a stop never arrives.
module interval_meter #(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned TICK_HZ       = 1_000_000,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned TIMEOUT_TICKS = 1_000_000,
  localparam int unsigned DIV          = CLK_FREQ / TICK_HZ,
  localparam int unsigned FRAC_W       = $clog2(DIV)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start_flag,
  input  logic              stop_flag,
  output logic              busy,
  output logic              meas_valid,
  output logic [CNT_W-1:0]  meas_ticks,
  output logic [FRAC_W-1:0] meas_frac,
  output logic              timeout_flag
);

  localparam logic [FRAC_W-1:0] PreMax     = FRAC_W'(DIV - 1);
  localparam logic [CNT_W:0]    TimeoutCmp = (CNT_W + 1)'(TIMEOUT_TICKS);
  localparam bit                TimeoutEn  = (TIMEOUT_TICKS != 0);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [FRAC_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic              meas_valid_q, meas_valid_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  meas_ticks_q, meas_ticks_d;
  logic [FRAC_W-1:0] meas_frac_q, meas_frac_d;

  logic              wrap;
  logic [CNT_W:0]    tick_inc;
  logic [CNT_W-1:0]  tick_sat;

  always_comb begin
    wrap     = (pre_cnt_q == PreMax);
    tick_inc = {1'b0, tick_cnt_q} + (CNT_W + 1)'(1);
    // Hold at all-ones rather than wrapping back to zero.
    tick_sat = tick_inc[CNT_W] ? tick_cnt_q : tick_inc[CNT_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    tick_cnt_d   = tick_cnt_q;
    meas_valid_d = 1'b0;
    timeout_d    = 1'b0;
    meas_ticks_d = meas_ticks_q;
    meas_frac_d  = meas_frac_q;

    unique case (state_q)
      StIdle: begin
        if (start_flag) begin
          state_d    = StRun;
          pre_cnt_d  = '0;
          tick_cnt_d = '0;
        end
      end
      StRun: begin
        if (stop_flag) begin
          // Counters reflect D-1 edges; fold in the stop edge itself.
          meas_valid_d = 1'b1;
          meas_ticks_d = wrap ? tick_sat : tick_cnt_q;
          meas_frac_d  = wrap ? '0 : pre_cnt_q + FRAC_W'(1);
          state_d      = StIdle;
        end else if (start_flag) begin
          pre_cnt_d  = '0;
          tick_cnt_d = '0;
        end else if (wrap) begin
          pre_cnt_d = '0;
          if (TimeoutEn && (tick_inc == TimeoutCmp)) begin
            timeout_d = 1'b1;
            state_d   = StIdle;
          end else begin
            tick_cnt_d = tick_sat;
          end
        end else begin
          pre_cnt_d = pre_cnt_q + FRAC_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= StIdle;
      pre_cnt_q    <= '0;
      tick_cnt_q   <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      meas_ticks_q <= '0;
      meas_frac_q  <= '0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
      meas_ticks_q <= meas_ticks_d;
      meas_frac_q  <= meas_frac_d;
    end
  end

  assign busy         = (state_q == StRun);
  assign meas_valid   = meas_valid_q;
  assign timeout_flag = timeout_q;
  assign meas_ticks   = meas_ticks_q;
  assign meas_frac    = meas_frac_q;

endmodule

// File: tb/tb_interval_meter.sv
// Bench for interval_meter: directed scenarios then random pulses, every cycle compared
// against an edge-counting reference model.
module tb_interval_meter;

  localparam int unsigned CLK_FREQ      = 1000;
  localparam int unsigned TICK_HZ       = 100;
  localparam int unsigned CNT_W         = 8;
  localparam int unsigned TIMEOUT_TICKS = 5;
  localparam int          DIV           = 10;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       start_flag = 1'b0;
  logic       stop_flag = 1'b0;
  logic       busy;
  logic       meas_valid;
  logic [7:0] meas_ticks;
  logic [3:0] meas_frac;
  logic       timeout_flag;

  interval_meter #(
    .CLK_FREQ     (CLK_FREQ),
    .TICK_HZ      (TICK_HZ),
    .CNT_W        (CNT_W),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .start_flag  (start_flag),
    .stop_flag   (stop_flag),
    .busy        (busy),
    .meas_valid  (meas_valid),
    .meas_ticks  (meas_ticks),
    .meas_frac   (meas_frac),
    .timeout_flag(timeout_flag)
  );

  always #5 sys_clk = ~sys_clk;

  int n_pass = 0;
  int n_checks = 0;

  // Reference model: remembers the edge index of the last start and derives results from D.
  int cyc = 0;
  bit running = 0;
  int start_cyc = 0;
  int e_busy = 0, e_valid = 0, e_to = 0, e_ticks = 0, e_frac = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s at edge %0d: got %0d required %0d", tag, cyc, got, exp);
  endtask

  task automatic step(input bit rst, input bit st, input bit sp);
    int d;
    sys_rst    = rst;
    start_flag = st;
    stop_flag  = sp;
    @(posedge sys_clk);
    cyc++;
    e_valid = 0;
    e_to    = 0;
    if (rst) begin
      running = 0;
      e_ticks = 0;
      e_frac  = 0;
    end else if (running) begin
      d = cyc - start_cyc;
      if (sp) begin
        e_valid = 1;
        e_ticks = d / DIV;
        e_frac  = d % DIV;
        running = 0;
      end else if (st) begin
        start_cyc = cyc;
      end else if (d == int'(TIMEOUT_TICKS) * DIV) begin
        e_to    = 1;
        running = 0;
      end
    end else if (st) begin
      running   = 1;
      start_cyc = cyc;
    end
    e_busy = running ? 1 : 0;
    #1;
    check("busy", int'(busy), e_busy);
    check("meas_valid", int'(meas_valid), e_valid);
    check("timeout_flag", int'(timeout_flag), e_to);
    check("meas_ticks", int'(meas_ticks), e_ticks);
    check("meas_frac", int'(meas_frac), e_frac);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  // Start at edge 0, stop at edge d.
  task automatic measure(input int d);
    step(0, 1, 0);
    idle(d - 1);
    step(0, 0, 1);
    idle(2);
  endtask

  initial begin
    // Reset held with start asserted.
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    idle(2);

    measure(37);
    measure(1);
    measure(9);
    measure(10);
    measure(50);

    // Timeout, then a late stop that must be ignored.
    step(0, 1, 0);
    idle(54);
    step(0, 0, 1);
    idle(3);

    // Restart at D=15, stop 23 edges later.
    step(0, 1, 0);
    idle(14);
    measure(23);

    // Start+stop together in IDLE, then together in RUN.
    step(0, 1, 1);
    idle(6);
    step(0, 1, 1);
    idle(3);

    // Reset mid-run, stop after reset.
    step(0, 1, 0);
    idle(19);
    step(1, 0, 0);
    idle(4);
    step(0, 0, 1);
    idle(3);

    // Random pulses.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 399) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 24) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/interval_meter.md
Name: interval_meter

Overview:
Measures the elapsed time between a start pulse and a stop pulse, in ticks of a programmable time base plus a residual count of clock cycles. It is the measuring counterpart of timer_start: timer_start produces a flag a fixed time after a start pulse, and interval_meter turns a start/stop pulse pair back into a duration. It sits beside timer_start in the timer group. It is used to check timer_start accuracy and to time external events, with a timeout for a stop that never arrives.

Parameters:
CLK_FREQ, 50_000_000, sys_clk frequency in Hz
TICK_HZ, 1_000_000, time-base rate in Hz; DIV = CLK_FREQ/TICK_HZ (integer, >= 2)
CNT_W, 32, width of tick counter and meas_ticks
TIMEOUT_TICKS, 1_000_000, tick count at which a run aborts; 0 disables the timeout

Ports:
sys_clk  in  1  system clock; all logic on its rising edge
sys_rst  in  1  synchronous, active-high reset
start_flag  in  1  single-cycle pulse that starts or restarts a measurement
stop_flag  in  1  single-cycle pulse that ends a measurement
busy  out  1  high while a measurement runs
meas_valid  out  1  one-cycle pulse when meas_ticks/meas_frac are updated
meas_ticks  out  CNT_W  whole ticks measured
meas_frac  out  FRAC_W  residual cycles, 0..DIV-1; FRAC_W = $clog2(DIV)
timeout_flag  out  1  one-cycle pulse when a run aborts

Behaviour:
- Reset (sys_rst sampled high): state IDLE. All outputs 0. pre_cnt = 0, tick_cnt = 0. Reset overrides every other input on that edge.
- State IDLE:
  - start_flag high -> RUN, pre_cnt = 0, tick_cnt = 0, busy = 1.
  - stop_flag alone is ignored.
  - start and stop in the same cycle -> start wins; stop is ignored.
- State RUN, no stop, no start, each edge:
  - If pre_cnt == DIV-1: pre_cnt = 0 and tick_cnt = tick_cnt + 1 (saturates at all-ones when TIMEOUT_TICKS = 0).
  - Otherwise pre_cnt = pre_cnt + 1.
- State RUN, stop_flag high (priority over start and timeout):
  - Let D = number of edges from the start-sampling edge to the stop-sampling edge.
  - meas_ticks = floor(D/DIV), computed as tick_cnt + (pre_cnt == DIV-1).
  - meas_frac = D mod DIV, computed as 0 if pre_cnt == DIV-1, else pre_cnt + 1.
  - meas_valid = 1 for exactly one cycle; busy = 0; state -> IDLE. All of this is registered on the sampling edge.
- State RUN, start_flag high (no stop): restart. pre_cnt = 0, tick_cnt = 0, stay in RUN, no meas_valid.
- Timeout (TIMEOUT_TICKS != 0): on the edge where tick_cnt would become TIMEOUT_TICKS:
  - timeout_flag = 1 for one cycle, busy = 0, state -> IDLE.
  - meas_ticks, meas_frac and meas_valid are unchanged.
  - A stop on that same edge wins instead (D = TIMEOUT_TICKS*DIV gives meas_ticks = TIMEOUT_TICKS, meas_frac = 0, no timeout).
- meas_ticks and meas_frac hold their value until the next valid measurement or reset.
- meas_valid and timeout_flag are never high in the same cycle.
- Reset during RUN: busy drops on that edge. No meas_valid, no timeout_flag. A later stop is ignored (IDLE).
- Minimum D = 1 (stop on the edge after start) gives meas_ticks = 0, meas_frac = 1.

Test Plan:
(All scenarios use CLK_FREQ=1000, TICK_HZ=100 so DIV=10, FRAC_W=4, CNT_W=8, TIMEOUT_TICKS=5.)
- Reset: hold sys_rst 3 cycles with start pulsed -> busy, meas_valid, timeout_flag, meas_ticks and meas_frac all 0 throughout.
- Basic: start at edge 0, stop at edge 37 -> meas_ticks=3, meas_frac=7, meas_valid high exactly 1 cycle, busy low after edge 37.
- Boundaries: D=1 -> (0,1). D=9 -> (0,9). D=10 -> (1,0). D=50 -> (5,0) with meas_valid and no timeout_flag.
- Timeout: start with no stop -> timeout_flag pulses on edge 50 after start, busy falls, meas_valid stays 0, previous meas_ticks/meas_frac retained. A stop at edge 55 is ignored.
- Restart and collisions:
  - Second start at D=15, stop 23 edges later -> (2,3), one meas_valid.
  - Start+stop together in IDLE -> busy=1, no meas_valid.
  - Start+stop together in RUN -> measurement emitted, state IDLE.
- Reset mid-run: start, sys_rst at D=20, stop at D=25 -> no meas_valid, no timeout_flag, busy 0 from the reset edge.
